// File: rtl/button_event_decoder_if.sv
// ---------------------------------------------------------------------------
// button_event_decoder_if
// Groups the level input and the event outputs of one button decoder.
//   in_level      debounced button level, synchronous to the decoder clock
//   pressed       registered "button is pressed" level
//   press_pulse   one-cycle press event
//   release_pulse one-cycle release event
//   long_pulse    one-cycle long-press event
//   repeat_pulse  one-cycle auto-repeat event while held
//   press_count   8-bit wrapping count of press events
// The slave modport is the decoder; the master modport is the consumer that
// supplies the level and watches the events.
// ---------------------------------------------------------------------------
interface button_event_decoder_if;
   logic       in_level;
   logic       pressed;
   logic       press_pulse;
   logic       release_pulse;
   logic       long_pulse;
   logic       repeat_pulse;
   logic [7:0] press_count;

   modport master (
      output in_level,
      input  pressed,
      input  press_pulse,
      input  release_pulse,
      input  long_pulse,
      input  repeat_pulse,
      input  press_count
   );

   modport slave (
      input  in_level,
      output pressed,
      output press_pulse,
      output release_pulse,
      output long_pulse,
      output repeat_pulse,
      output press_count
   );
endinterface

// File: rtl/button_event_decoder.sv
// ---------------------------------------------------------------------------
// button_event_decoder
// Turns a debounced button level into single-cycle press / release /
// long-press / auto-repeat events, plus a registered pressed level and a
// wrapping 8-bit press counter. Every output is registered.
// Ports:
//   clk    system clock, all logic on its rising edge
//   rst_n  asynchronous active-low reset
//   bus    button_event_decoder_if.slave (in_level in, events out)
// Parameters:
//   ACTIVE_LEVEL      in_level value meaning "pressed"
//   CNT_WIDTH         width of the hold and repeat counters
//   LONG_PRESS_CYCLES cycles from press_pulse to long_pulse (2..2^CNT_WIDTH-1)
//   REPEAT_PERIOD     cycles between repeat_pulses after long_pulse, 0 = off
// ---------------------------------------------------------------------------
module button_event_decoder #(
   parameter bit ACTIVE_LEVEL      = 1'b1,
   parameter int CNT_WIDTH         = 16,
   parameter int LONG_PRESS_CYCLES = 1000,
   parameter int REPEAT_PERIOD     = 250
) (
   input  logic                  clk,
   input  logic                  rst_n,
   button_event_decoder_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESSED = 2'd1,
      HELD    = 2'd2
   } state_t;

   // hold_cnt is 0 in the press_pulse cycle and counts one per cycle, so the
   // long event is decided on the edge where it reaches LONG_PRESS_CYCLES-1.
   localparam logic [CNT_WIDTH-1:0] LONG_LAST = CNT_WIDTH'(LONG_PRESS_CYCLES - 1);
   localparam bit                   REP_EN    = (REPEAT_PERIOD != 0);
   localparam logic [CNT_WIDTH-1:0] REP_LAST  = CNT_WIDTH'(REP_EN ? REPEAT_PERIOD - 1 : 0);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

   state_t               state_q, state_d;
   logic                 prev_q;
   logic [CNT_WIDTH-1:0] hold_cnt_q, hold_cnt_d;
   logic [CNT_WIDTH-1:0] rep_cnt_q, rep_cnt_d;
   logic [7:0]           press_count_q, press_count_d;
   logic                 pressed_q;
   logic                 press_q, press_d;
   logic                 release_q, release_d;
   logic                 long_q, long_d;
   logic                 repeat_q, repeat_d;
   logic                 act;

   assign act = (bus.in_level == ACTIVE_LEVEL);

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         prev_q        <= 1'b0;
         hold_cnt_q    <= '0;
         rep_cnt_q     <= '0;
         press_count_q <= '0;
         pressed_q     <= 1'b0;
         press_q       <= 1'b0;
         release_q     <= 1'b0;
         long_q        <= 1'b0;
         repeat_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         prev_q        <= act;
         hold_cnt_q    <= hold_cnt_d;
         rep_cnt_q     <= rep_cnt_d;
         press_count_q <= press_count_d;
         pressed_q     <= act;
         press_q       <= press_d;
         release_q     <= release_d;
         long_q        <= long_d;
         repeat_q      <= repeat_d;
      end
   end

   // Next-state logic; release is checked first so it wins over thresholds
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (act && !prev_q) state_d = PRESSED;
         end
         PRESSED: begin
            if (!act)                         state_d = IDLE;
            else if (hold_cnt_q == LONG_LAST) state_d = HELD;
         end
         HELD: begin
            if (!act) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Event and counter next values
   always_comb begin
      press_d       = 1'b0;
      release_d     = 1'b0;
      long_d        = 1'b0;
      repeat_d      = 1'b0;
      hold_cnt_d    = hold_cnt_q;
      rep_cnt_d     = rep_cnt_q;
      press_count_d = press_count_q;
      case (state_q)
         IDLE: begin
            if (act && !prev_q) begin
               press_d       = 1'b1;
               press_count_d = press_count_q + 8'd1;
               hold_cnt_d    = '0;
               rep_cnt_d     = '0;
            end
         end
         PRESSED: begin
            if (!act) begin
               release_d  = 1'b1;
               hold_cnt_d = '0;
               rep_cnt_d  = '0;
            end else if (hold_cnt_q == LONG_LAST) begin
               // hold_cnt parks at the threshold for the rest of the hold
               long_d    = 1'b1;
               rep_cnt_d = '0;
            end else begin
               hold_cnt_d = hold_cnt_q + CNT_ONE;
            end
         end
         HELD: begin
            if (!act) begin
               release_d  = 1'b1;
               hold_cnt_d = '0;
               rep_cnt_d  = '0;
            end else if (REP_EN) begin
               if (rep_cnt_q == REP_LAST) begin
                  repeat_d  = 1'b1;
                  rep_cnt_d = '0;
               end else begin
                  rep_cnt_d = rep_cnt_q + CNT_ONE;
               end
            end
         end
         default: begin
            hold_cnt_d = '0;
            rep_cnt_d  = '0;
         end
      endcase
   end

   assign bus.pressed       = pressed_q;
   assign bus.press_pulse   = press_q;
   assign bus.release_pulse = release_q;
   assign bus.long_pulse    = long_q;
   assign bus.repeat_pulse  = repeat_q;
   assign bus.press_count   = press_count_q;

endmodule

// File: tb/tb_button_event_decoder.sv
module tb_button_event_decoder;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   vectors = 0;
   int   errors  = 0;

   always #5 clk = ~clk;

   // Default instance: active-high, long = 1000, repeat = 250
   button_event_decoder_if bus1();
   // Second instance: active-low input, repeat disabled
   button_event_decoder_if bus2();

   button_event_decoder dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1)
   );

   button_event_decoder #(
      .ACTIVE_LEVEL      (1'b0),
      .CNT_WIDTH         (16),
      .LONG_PRESS_CYCLES (1000),
      .REPEAT_PERIOD     (0)
   ) dut2 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus2)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [5:0] outs1();
      return {bus1.pressed, bus1.press_pulse, bus1.release_pulse,
              bus1.long_pulse, bus1.repeat_pulse, |bus1.press_count};
   endfunction

   function automatic logic [5:0] outs2();
      return {bus2.pressed, bus2.press_pulse, bus2.release_pulse,
              bus2.long_pulse, bus2.repeat_pulse, |bus2.press_count};
   endfunction

   task automatic test_reset();
      bus1.in_level = 1'b0;
      bus2.in_level = 1'b1;
      rst_n = 1'b0;
      #1;
      vectors++;
      if (outs1() !== 6'b0) begin
         errors++; $display("FAIL reset_outs1: got %b expected 000000", outs1());
      end
      tick(); tick();
      rst_n = 1'b1;
      tick();
      vectors++;
      if (outs1() !== 6'b0 || outs2() !== 6'b0) begin
         errors++; $display("FAIL reset_idle: got %b/%b expected 000000/000000", outs1(), outs2());
      end
   endtask

   task automatic test_short_press();
      int npress = 0, nrel = 0, nlong = 0;
      bus1.in_level = 1'b1;
      tick();
      vectors++;
      if (bus1.press_pulse !== 1'b1 || bus1.pressed !== 1'b1 || bus1.press_count !== 8'd1) begin
         errors++; $display("FAIL short_press_edge: got press=%b pressed=%b cnt=%0d expected 1 1 1",
                            bus1.press_pulse, bus1.pressed, bus1.press_count);
      end
      for (int n = 2; n <= 10; n++) begin
         tick();
         npress += int'(bus1.press_pulse);
         nrel   += int'(bus1.release_pulse);
         nlong  += int'(bus1.long_pulse);
      end
      bus1.in_level = 1'b0;
      tick();
      vectors++;
      if (bus1.release_pulse !== 1'b1 || bus1.pressed !== 1'b0) begin
         errors++; $display("FAIL short_release_edge: got rel=%b pressed=%b expected 1 0",
                            bus1.release_pulse, bus1.pressed);
      end
      for (int n = 0; n < 5; n++) begin
         tick();
         npress += int'(bus1.press_pulse);
         nrel   += int'(bus1.release_pulse);
         nlong  += int'(bus1.long_pulse);
      end
      vectors++;
      if (npress !== 0 || nrel !== 0 || nlong !== 0 || bus1.press_count !== 8'd1) begin
         errors++; $display("FAIL short_extra_pulses: got press=%0d rel=%0d long=%0d cnt=%0d expected 0 0 0 1",
                            npress, nrel, nlong, bus1.press_count);
      end
   endtask

   task automatic test_long_repeat();
      int long_n = -1, nlong = 0, nrep = 0, nmulti = 0, nlow = 0;
      int rep_n[3] = '{-1, -1, -1};
      bus1.in_level = 1'b1;
      for (int n = 1; n <= 1770; n++) begin
         tick();
         if (n == 1) begin
            vectors++;
            if (bus1.press_pulse !== 1'b1 || bus1.press_count !== 8'd2) begin
               errors++; $display("FAIL long_press_edge: got press=%b cnt=%0d expected 1 2",
                                  bus1.press_pulse, bus1.press_count);
            end
         end
         if (bus1.long_pulse) begin nlong++; long_n = n; end
         if (bus1.repeat_pulse) begin
            if (nrep < 3) rep_n[nrep] = n;
            nrep++;
         end
         if (int'(bus1.press_pulse) + int'(bus1.release_pulse) +
             int'(bus1.long_pulse) + int'(bus1.repeat_pulse) > 1) nmulti++;
         if (!bus1.pressed) nlow++;
      end
      vectors++;
      if (nlong !== 1 || long_n !== 1001) begin
         errors++; $display("FAIL long_timing: got count=%0d at=%0d expected 1 at 1001", nlong, long_n);
      end
      vectors++;
      if (nrep !== 3 || rep_n[0] !== 1251 || rep_n[1] !== 1501 || rep_n[2] !== 1751) begin
         errors++; $display("FAIL repeat_timing: got n=%0d at %0d,%0d,%0d expected 3 at 1251,1501,1751",
                            nrep, rep_n[0], rep_n[1], rep_n[2]);
      end
      vectors++;
      if (nmulti !== 0 || nlow !== 0) begin
         errors++; $display("FAIL hold_onehot_level: got multi=%0d low=%0d expected 0 0", nmulti, nlow);
      end
      bus1.in_level = 1'b0;
      tick();
      vectors++;
      if (bus1.release_pulse !== 1'b1 || bus1.repeat_pulse !== 1'b0 || bus1.pressed !== 1'b0) begin
         errors++; $display("FAIL held_release: got rel=%b rep=%b pressed=%b expected 1 0 0",
                            bus1.release_pulse, bus1.repeat_pulse, bus1.pressed);
      end
   endtask

   task automatic test_release_at_threshold();
      int nlong = 0;
      bus1.in_level = 1'b1;
      for (int n = 1; n <= 1000; n++) begin
         tick();
         nlong += int'(bus1.long_pulse);
      end
      // act is low on the edge that would have produced long_pulse
      bus1.in_level = 1'b0;
      tick();
      vectors++;
      if (bus1.release_pulse !== 1'b1 || bus1.long_pulse !== 1'b0) begin
         errors++; $display("FAIL thresh_release: got rel=%b long=%b expected 1 0",
                            bus1.release_pulse, bus1.long_pulse);
      end
      for (int n = 0; n < 20; n++) begin
         tick();
         nlong += int'(bus1.long_pulse) + int'(bus1.repeat_pulse) + int'(bus1.release_pulse);
      end
      vectors++;
      if (nlong !== 0) begin
         errors++; $display("FAIL thresh_no_long: got %0d extra pulses expected 0", nlong);
      end
   endtask

   task automatic test_reset_in_held();
      bus1.in_level = 1'b1;
      for (int n = 1; n <= 1100; n++) tick();
      vectors++;
      if (bus1.pressed !== 1'b1 || bus1.press_count !== 8'd4) begin
         errors++; $display("FAIL pre_reset_state: got pressed=%b cnt=%0d expected 1 4",
                            bus1.pressed, bus1.press_count);
      end
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if (outs1() !== 6'b0) begin
         errors++; $display("FAIL async_reset_outs: got %b expected 000000", outs1());
      end
      tick(); tick();
      vectors++;
      if (outs1() !== 6'b0) begin
         errors++; $display("FAIL held_in_reset: got %b expected 000000", outs1());
      end
      rst_n = 1'b1;
      tick();
      vectors++;
      if (bus1.press_pulse !== 1'b1 || bus1.pressed !== 1'b1 || bus1.press_count !== 8'd1) begin
         errors++; $display("FAIL post_reset_press: got press=%b pressed=%b cnt=%0d expected 1 1 1",
                            bus1.press_pulse, bus1.pressed, bus1.press_count);
      end
      tick();
      vectors++;
      if (bus1.press_pulse !== 1'b0) begin
         errors++; $display("FAIL post_reset_single: got press=%b expected 0", bus1.press_pulse);
      end
      bus1.in_level = 1'b0;
      tick();
      vectors++;
      if (bus1.release_pulse !== 1'b1) begin
         errors++; $display("FAIL post_reset_release: got rel=%b expected 1", bus1.release_pulse);
      end
   endtask

   task automatic test_count_wrap();
      int npress = 0, nrel = 0;
      logic [7:0] cnt_at_256 = 8'hFF;
      bus1.in_level = 1'b0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      for (int i = 1; i <= 257; i++) begin
         bus1.in_level = 1'b1;
         tick();
         npress += int'(bus1.press_pulse);
         if (i == 256) cnt_at_256 = bus1.press_count;
         bus1.in_level = 1'b0;
         tick();
         nrel += int'(bus1.release_pulse);
      end
      tick();
      vectors++;
      if (npress !== 257 || nrel !== 257) begin
         errors++; $display("FAIL wrap_pulse_counts: got press=%0d rel=%0d expected 257 257", npress, nrel);
      end
      vectors++;
      if (cnt_at_256 !== 8'd0) begin
         errors++; $display("FAIL wrap_at_256: got %0d expected 0", cnt_at_256);
      end
      vectors++;
      if (bus1.press_count !== 8'd1) begin
         errors++; $display("FAIL wrap_final_count: got %0d expected 1", bus1.press_count);
      end
   endtask

   task automatic test_active_low_no_repeat();
      int long_n = -1, nlong = 0, nrep = 0, nlow = 0, npress = 0;
      bus2.in_level = 1'b0;
      for (int n = 1; n <= 2000; n++) begin
         tick();
         if (n == 1) begin
            vectors++;
            if (bus2.press_pulse !== 1'b1 || bus2.press_count !== 8'd1) begin
               errors++; $display("FAIL al_press_edge: got press=%b cnt=%0d expected 1 1",
                                  bus2.press_pulse, bus2.press_count);
            end
         end else begin
            npress += int'(bus2.press_pulse);
         end
         if (bus2.long_pulse) begin nlong++; long_n = n; end
         nrep += int'(bus2.repeat_pulse);
         if (bus2.pressed !== 1'b1) nlow++;
      end
      vectors++;
      if (nlong !== 1 || long_n !== 1001) begin
         errors++; $display("FAIL al_long_timing: got count=%0d at=%0d expected 1 at 1001", nlong, long_n);
      end
      vectors++;
      if (nrep !== 0 || npress !== 0) begin
         errors++; $display("FAIL al_no_repeat: got rep=%0d extra press=%0d expected 0 0", nrep, npress);
      end
      vectors++;
      if (nlow !== 0) begin
         errors++; $display("FAIL al_pressed_level: got %0d cycles not pressed expected 0", nlow);
      end
      bus2.in_level = 1'b1;
      tick();
      vectors++;
      if (bus2.release_pulse !== 1'b1 || bus2.pressed !== 1'b0) begin
         errors++; $display("FAIL al_release: got rel=%b pressed=%b expected 1 0",
                            bus2.release_pulse, bus2.pressed);
      end
   endtask

   initial begin
      test_reset();
      test_short_press();
      test_long_repeat();
      test_release_at_threshold();
      test_reset_in_held();
      test_count_wrap();
      test_active_low_no_repeat();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
